uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one `uart_tx` instance between `N_REQ` byte-stream requesters. Round-robin arbitration with per-packet lock: a granted requester keeps the transmitter until its byte flagged `last` has finished on the line. Sits between the on-chip clients and `uart_tx`, driving its `tx_start`/`data_in` and consuming its `tx_done`. Includes a watchdog so a stalled requester or a missing `tx_done` cannot hang the link.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width; must match `uart_tx`.
- `TIMEOUT`, default 65535: cycles allowed in LOAD (lock held) or WAIT before abort.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a byte on `req_data[i]`.
- `req_data`  in  N_REQ*DATA_W  packed bytes; requester i at bits `[i*DATA_W +: DATA_W]`.
- `req_last`  in  N_REQ  the current byte ends requester i's packet.
- `req_ready`  out  N_REQ  one-hot accept strobe; transfer occurs when `req_valid[i] & req_ready[i]`.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  DATA_W  byte to `uart_tx`; stable from the SEND cycle until `tx_done`.
- `tx_done`  in  1  one-cycle pulse from `uart_tx` after the stop bit.
- `grant_id`  out  $clog2(N_REQ)  index of the current owner; valid while `busy`.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states:
  - IDLE
  - LOAD: `req_ready[grant]` driven = `req_valid[grant]`.
  - SEND: `tx_start` = 1.
  - WAIT: wait for `tx_done`.
- IDLE → LOAD when any `req_valid` is high.
  - Winner is the first valid index searching upward from `ptr+1`, modulo `N_REQ`.
  - `grant_id` is registered on entry to LOAD.
- LOAD:
  - On a transfer, capture `req_data[grant]` into `tx_data` and `req_last[grant]` into `last_q`, then go to SEND.
  - If `req_valid[grant]` is low, stay in LOAD (lock held) and run the watchdog.
- SEND → WAIT unconditionally after one cycle.
- WAIT on `tx_done`:
  - If `last_q`: `ptr <= grant_id`, go to IDLE.
  - Otherwise go back to LOAD with the same grant.
- Watchdog:
  - Counter clears on every state entry and increments in LOAD and WAIT.
  - On reaching `TIMEOUT`: pulse `timeout_err`, set `ptr <= grant_id`, go to IDLE.
  - Other requesters then get service. No partial byte is retracted.
- `tx_done` is ignored outside WAIT.
- Requesters other than `grant_id` never see `req_ready` while a lock is held, whatever their `req_valid`.
- Simultaneous requests in IDLE resolve purely by the rotating pointer; there is no fixed priority.
- Reset values:
  - FSM = IDLE; `ptr` = `N_REQ-1`, so requester 0 wins first.
  - `tx_start`, `tx_data`, `req_ready`, `grant_id`, `busy`, `timeout_err` = 0; `last_q` = 0; watchdog = 0.
- Reset mid-packet returns to IDLE immediately. The `uart_tx` frame in flight is not this block's concern.

## Timing
- Cycle 0: IDLE samples `req_valid`.
- Cycle 1: LOAD, `req_ready` high, byte captured at the clock edge.
- Cycle 2: `tx_start` pulse. Cycle 3 onward: WAIT.
- Best-case request-to-`tx_start` latency: 2 cycles.
- Within a packet, the next byte's `req_ready` comes 1 cycle after `tx_done`, and its `tx_start` 2 cycles after `tx_done`.
- Gap between packets of different requesters: `tx_done` → IDLE (+1) → LOAD (+2) → `tx_start` (+3).
- All outputs are registered or decoded from registered state only; no combinational path from `req_*` inputs to outputs except `req_ready`, which is gated by the registered grant and state.

## Structure
- Shared package `uart_pkg`:
  - `uart_arb_state_t` enum {IDLE, LOAD, SEND, WAIT}.
  - `UART_DATA_W` = 8.
  - Baud constants `CLK_FRE` = 50000000 and `BAUD_RATE` = 115200, used by the top level.
- One sub-module, `rr_pick`: combinational rotating-priority encoder. Inputs: `req` vector and `ptr`. Outputs: `any` and `idx`.
- Top level instantiates this block in front of `uart_tx`; `uart_rx` loopback is unchanged.

## Test plan
- After reset, requester 2 alone sends 0xA5 with `last`=1 → `req_ready[2]` at cycle 1, `tx_start` at cycle 2 with `tx_data`=0xA5, `busy` falls one cycle after `tx_done`.
- Requesters 0 and 1 raise valid in the same cycle, each with a 3-byte packet (0x10,0x11,0x12 / 0x20,0x21,0x22) → line carries 0x10,0x11,0x12,0x20,0x21,0x22; requester 1 is never readied during packet 0.
- Requesters 0–3 all continuously valid with single-byte packets → grant order 0,1,2,3,0,1; no requester is starved.
- Requester 1 drops valid after byte 1 of a 2-byte packet, `TIMEOUT`=100 → `timeout_err` pulses 100 cycles after LOAD entry, then pending requester 3 is granted next.
- Reset asserted during WAIT → next cycle all outputs are 0, `busy`=0; a new request from 0 is served first.
- `tx_done` is pulsed during IDLE and during SEND → no state change, no extra `req_ready`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path and its arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      WAIT = 2'd3
   } uart_arb_state_t;

   localparam int UART_DATA_W = 8;
   localparam int CLK_FRE     = 50000000;
   localparam int BAUD_RATE   = 115200;

   // Index reached by stepping 'off' places upward from 'base' in a ring of n.
   function automatic int rr_wrap(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req searching upward from ptr+1,
// wrapping modulo N_REQ. Purely combinational.
module rr_pick
   import uart_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   // Walk the ring from the far end back to ptr+1 so the nearest hit wins.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'(rr_wrap(int'(ptr), k + 1, N_REQ));
         if (req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte-stream requesters.
// A grant is locked for a whole packet (until the byte flagged last finishes on
// the line); a watchdog aborts a stalled LOAD or a missing tx_done.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; pick next requester from the rotating pointer
//   LOAD  | owner locked; req_ready follows its req_valid, byte captured
//   SEND  | one-cycle tx_start pulse with the captured byte
//   WAIT  | byte on the line; wait for tx_done
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = UART_DATA_W,
   parameter int TIMEOUT = 65535
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_done,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   // The abort fires at the edge that would take the count to TIMEOUT.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   uart_arb_state_t   state;
   uart_arb_state_t   state_nx;
   logic [IDX_W-1:0]  ptr;
   logic              last_q;
   logic [WD_W-1:0]   wd;
   logic              pick_any;
   logic [IDX_W-1:0]  pick_idx;
   logic              sel_valid;
   logic              sel_last;
   logic [DATA_W-1:0] sel_data;
   logic              xfer;
   logic              wd_expired;
   logic              timeout_hit;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Route the granted requester's lane onto the shared selection signals.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == IDX_W'(i)) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign xfer       = (state == LOAD) && sel_valid;
   assign wd_expired = (wd == WD_LAST);

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_nx    = state;
      timeout_hit = 1'b0;
      req_ready   = '0;
      tx_start    = (state == SEND);
      busy        = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (pick_any) state_nx = LOAD;
         end
         LOAD: begin
            for (int i = 0; i < N_REQ; i++) begin
               req_ready[i] = (grant_id == IDX_W'(i)) && req_valid[i];
            end
            if (sel_valid) begin
               state_nx = SEND;
            end else if (wd_expired) begin
               state_nx    = IDLE;
               timeout_hit = 1'b1;
            end
         end
         SEND: begin
            state_nx = WAIT;
         end
         WAIT: begin
            if (tx_done) begin
               state_nx = last_q ? IDLE : LOAD;
            end else if (wd_expired) begin
               state_nx    = IDLE;
               timeout_hit = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register and registered abort pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         timeout_err <= timeout_hit;
      end
   end

   // Grant, pointer and captured byte; pointer moves only when ownership ends.
   always_ff @(posedge clk) begin
      if (!reset) begin
         grant_id <= '0;
         ptr      <= IDX_W'(N_REQ - 1);
         tx_data  <= '0;
         last_q   <= 1'b0;
      end else begin
         if (state == IDLE && pick_any) grant_id <= pick_idx;
         if (xfer) begin
            tx_data <= sel_data;
            last_q  <= sel_last;
         end
         if ((state == WAIT && tx_done && last_q) || timeout_hit) ptr <= grant_id;
      end
   end

   // Watchdog: clears on every state change, counts while in LOAD or WAIT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wd <= '0;
      end else if (state_nx != state) begin
         wd <= '0;
      end else if (state == LOAD || state == WAIT) begin
         wd <= wd + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for single-byte timing and
// stray tx_done, then hand sequences with a simple uart_tx model.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_start;
   logic [W-1:0]   tx_data;
   logic           tx_done;
   logic [1:0]     grant_id;
   logic           busy;
   logic           timeout_err;

   logic tx_done_tb;
   logic model_en;
   logic model_done;
   int   mcnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] line_q[$];
   logic [1:0]   gnt_q[$];
   logic [8:0]   src_q[N][$];
   logic [N-1:0] stall;
   logic         stall_arm1;
   int cyc, viol, terr_cnt, terr_cyc, done_cyc;

   assign tx_done = model_en ? model_done : tx_done_tb;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(100)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // uart_tx stand-in: logs each started byte and answers with tx_done later.
   always @(posedge clk) begin
      if (!model_en) begin
         mcnt       <= 0;
         model_done <= 1'b0;
      end else begin
         model_done <= 1'b0;
         if (tx_start) begin
            line_q.push_back(tx_data);
            gnt_q.push_back(grant_id);
            mcnt <= 6;
         end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) model_done <= 1'b1;
         end
      end
   end

   typedef struct {
      logic [N-1:0]   valid;
      logic [N*W-1:0] data;
      logic [N-1:0]   last;
      logic           done;
      logic [N-1:0]   ready;
      logic           start;
      logic           bsy;
      logic [1:0]     grant;
      logic           chk_data;
      logic [W-1:0]   txd;
      logic           terr;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() != 0 && !stall[i]) begin
            req_valid[i]       = 1'b1;
            req_data[i*W +: W] = src_q[i][0][7:0];
            req_last[i]        = src_q[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*W +: W] = '0;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   function automatic bit pending();
      bit p = 0;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0 && !stall[i]) p = 1;
      return p;
   endfunction

   task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      if (busy && ((req_ready & ~(4'b0001 << grant_id)) != 4'b0000)) viol++;
      if (timeout_err) begin
         terr_cnt++;
         terr_cyc = cyc;
      end
      if (tx_done && busy && terr_cnt == 0) done_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            void'(src_q[i].pop_front());
            if (i == 1 && stall_arm1) stall[1] = 1'b1;
         end
      end
      drive();
   endtask

   task automatic run_until_idle(input string nm, input int budget);
      bit ok = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         step();
         if (!pending() && !busy) ok = 1;
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: did not go idle within %0d cycles", nm, budget);
      end
   endtask

   task automatic do_reset();
      model_en = 1'b0;
      reset    = 1'b0;
      for (int i = 0; i < N; i++) src_q[i].delete();
      stall      = '0;
      stall_arm1 = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b1;
      model_en = 1'b1;
      cyc = 0; terr_cnt = 0; terr_cyc = 0; done_cyc = -1000;
   endtask

   initial begin
      int gb, lb;
      reset = 1'b0; model_en = 1'b0; tx_done_tb = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0;
      stall = '0; stall_arm1 = 1'b0; viol = 0;

      //          valid    data          last     dn  ready    st bsy g  cd txd    te
      vt[0]  = '{4'b0100, 32'h00A50000, 4'b0100, 0, 4'b0000, 0, 0, 0, 0, 8'h00, 0};
      vt[1]  = '{4'b0100, 32'h00A50000, 4'b0100, 0, 4'b0100, 0, 1, 2, 0, 8'h00, 0};
      vt[2]  = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 1, 1, 2, 1, 8'hA5, 0};
      vt[3]  = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 1, 2, 1, 8'hA5, 0};
      vt[4]  = '{4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 1, 2, 1, 8'hA5, 0};
      vt[5]  = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 8'h00, 0};
      vt[6]  = '{4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 8'h00, 0};
      vt[7]  = '{4'b0001, 32'h00000033, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 8'h00, 0};
      vt[8]  = '{4'b0001, 32'h00000033, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, 8'h00, 0};
      vt[9]  = '{4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 1, 1, 0, 1, 8'h33, 0};
      vt[10] = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 1, 0, 1, 8'h33, 0};
      vt[11] = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 1, 0, 1, 8'h33, 0};
      vt[12] = '{4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 1, 0, 1, 8'h33, 0};
      vt[13] = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 8'h00, 0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_terr", timeout_err, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Cycle table: single byte from requester 2, then stray tx_done in IDLE/SEND
      for (int k = 0; k < 14; k++) begin
         req_valid  = vt[k].valid;
         req_data   = vt[k].data;
         req_last   = vt[k].last;
         tx_done_tb = vt[k].done;
         @(negedge clk);
         chk($sformatf("v%0d_ready", k), req_ready, vt[k].ready);
         chk($sformatf("v%0d_start", k), tx_start, vt[k].start);
         chk($sformatf("v%0d_busy", k), busy, vt[k].bsy);
         chk($sformatf("v%0d_terr", k), timeout_err, vt[k].terr);
         if (vt[k].bsy) chk($sformatf("v%0d_grant", k), grant_id, vt[k].grant);
         if (vt[k].chk_data) chk($sformatf("v%0d_txdata", k), tx_data, vt[k].txd);
         @(posedge clk);
         #1;
      end
      tx_done_tb = 1'b0;

      // Two simultaneous 3-byte packets: packet lock, no interleave
      do_reset();
      viol = 0;
      gb = gnt_q.size(); lb = line_q.size();
      src_q[0].push_back(9'h010); src_q[0].push_back(9'h011); src_q[0].push_back(9'h112);
      src_q[1].push_back(9'h020); src_q[1].push_back(9'h021); src_q[1].push_back(9'h122);
      drive();
      run_until_idle("pkt_lock", 500);
      chk("pkt_lock_count", line_q.size() - lb, 6);
      begin
         logic [7:0] exp_b[6] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
         for (int k = 0; k < 6; k++)
            if (lb + k < line_q.size()) chk($sformatf("pkt_lock_byte%0d", k), line_q[lb+k], exp_b[k]);
      end
      chk("pkt_lock_foreign_ready", viol, 0);

      // All four continuously valid with single-byte packets: strict rotation
      do_reset();
      gb = gnt_q.size(); lb = line_q.size();
      for (int i = 0; i < N; i++) begin
         src_q[i].push_back(9'h130 + 9'(i));
         src_q[i].push_back(9'h140 + 9'(i));
      end
      drive();
      run_until_idle("rotate", 500);
      chk("rotate_count", gnt_q.size() - gb, 8);
      for (int k = 0; k < 8; k++) begin
         if (gb + k < gnt_q.size()) begin
            chk($sformatf("rotate_grant%0d", k), gnt_q[gb+k], k % 4);
            chk($sformatf("rotate_byte%0d", k), line_q[lb+k], (k < 4 ? 8'h30 : 8'h40) + 8'(k % 4));
         end
      end

      // Requester 1 stalls mid-packet: watchdog aborts, requester 3 next
      do_reset();
      gb = gnt_q.size(); lb = line_q.size();
      stall_arm1 = 1'b1;
      src_q[1].push_back(9'h050); src_q[1].push_back(9'h151);
      src_q[3].push_back(9'h170);
      drive();
      run_until_idle("timeout", 600);
      chk("timeout_pulses", terr_cnt, 1);
      chk("timeout_delay", terr_cyc - (done_cyc + 1), 100);
      chk("timeout_count", line_q.size() - lb, 2);
      if (line_q.size() - lb >= 2) begin
         chk("timeout_byte0", line_q[lb], 8'h50);
         chk("timeout_byte1", line_q[lb+1], 8'h70);
         chk("timeout_next_grant", gnt_q[gb+1], 3);
      end
      chk("timeout_retained", src_q[1].size(), 1);

      // Reset during WAIT: outputs clear, pointer back to requester 0 first
      do_reset();
      src_q[0].push_back(9'h101);
      src_q[2].push_back(9'h199);
      drive();
      gb = gnt_q.size();
      for (int n = 0; n < 100 && (gnt_q.size() - gb) < 2; n++) step();
      step(); step();
      chk("midrst_pre_busy", busy, 1);
      chk("midrst_pre_grant", grant_id, 2);
      model_en = 1'b0;
      src_q[0].push_back(9'h10A);
      src_q[1].push_back(9'h11B);
      drive();
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_tx_start", tx_start, 0);
      chk("midrst_tx_data", tx_data, 0);
      chk("midrst_grant", grant_id, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_terr", timeout_err, 0);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      model_en = 1'b1;
      gb = gnt_q.size(); lb = line_q.size();
      run_until_idle("midrst", 300);
      chk("midrst_count", gnt_q.size() - gb, 2);
      if (gnt_q.size() - gb >= 2) begin
         chk("midrst_first_grant", gnt_q[gb], 0);
         chk("midrst_first_byte", line_q[lb], 8'h0A);
         chk("midrst_second_grant", gnt_q[gb+1], 1);
      end
      chk("all_foreign_ready", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
